// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared types and byte constants for the PS/2 Set-2 scan-code decoder.
// Imported by the decoder top and its event FIFO.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] ACK       = 8'hFA;
  localparam logic [7:0] BAT_OK    = 8'hAA;
  localparam logic [7:0] ECHO      = 8'hEE;
  localparam logic [7:0] RESEND    = 8'hFE;
  localparam logic [7:0] ERR0      = 8'h00;
  localparam logic [7:0] ERR1      = 8'hFF;

  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } evt_t;

  function automatic logic is_housekeeping(input logic [7:0] b);
    return (b == ACK) || (b == BAT_OK) || (b == ECHO) || (b == RESEND);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Key-event valid/ready channel toward the application logic.
// master drives the event, slave drives the ready.
interface ps2_evt_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_ext,
    output evt_release,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_ext,
    input  evt_release,
    output evt_ready
  );
endinterface

// File: rtl/ps2_scancode_decoder_fifo.sv
// Show-ahead key-event FIFO with pointer + count bookkeeping.
// A push into a full FIFO succeeds only when a pop frees a slot the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  evt_t din,
  input  logic pop,
  output evt_t dout,
  output logic valid,
  output logic drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  evt_t          mem_q [DEPTH];
  evt_t          mem_d [DEPTH];

  logic full, empty, pop_ok, push_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign valid   = ~empty;
  assign dout    = empty ? '0 : mem_q[rd_q];

  // Next pointers, occupancy and storage.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count registers; storage needs no reset since dout is gated.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Event storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code sequence decoder with Shift tracking and event FIFO.
// One byte per rx_valid strobe; events leave on a valid/ready channel.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  ps2_evt_if.master  evt,
  output logic       shift,
  output logic       overflow,
  input  logic       clr_ovf
);

  ps2_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       lsh_q, lsh_d;
  logic       rsh_q, rsh_d;
  logic       ovf_q, ovf_d;

  logic emit;
  evt_t ev;
  evt_t head;
  logic drop;
  logic in_ext, in_brk;

  assign in_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign in_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

  // Sequence FSM: prefixes, pause skipping, filtering and event emission.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    ev      = '0;
    if (rx_valid) begin
      if (state_q == ST_SKIP) begin
        skip_d = skip_q - 3'd1;
        if (skip_q <= 3'd1) begin
          state_d = ST_IDLE;
        end
      end else begin
        unique case (1'b1)
          (rx_data == ERR0) || (rx_data == ERR1): begin
            state_d = ST_IDLE;
          end
          is_housekeeping(rx_data): begin
            state_d = state_q;
          end
          rx_data == SC_EXT: begin
            state_d = ST_EXT;
          end
          rx_data == SC_BRK: begin
            state_d = in_ext ? ST_EXT_BRK : ST_BRK;
          end
          (rx_data == SC_PAUSE) && (state_q == ST_IDLE): begin
            emit    = 1'b1;
            ev      = '{ext: 1'b0, rel: 1'b0, code: SC_PAUSE};
            skip_d  = PAUSE_TAIL;
            state_d = ST_SKIP;
          end
          default: begin
            emit    = 1'b1;
            ev      = '{ext: in_ext, rel: in_brk, code: rx_data};
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Shift level from non-extended events, independent of FIFO space.
  always_comb begin
    lsh_d = lsh_q;
    rsh_d = rsh_q;
    if (emit && !ev.ext) begin
      if (ev.code == SC_LSHIFT) lsh_d = ~ev.rel;
      if (ev.code == SC_RSHIFT) rsh_d = ~ev.rel;
    end
  end

  // Sticky overflow; a new drop wins over a clear.
  always_comb begin
    ovf_d = drop | (ovf_q & ~clr_ovf);
  end

  // Decoder state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (emit),
    .din   (ev),
    .pop   (evt.evt_ready),
    .dout  (head),
    .valid (evt.evt_valid),
    .drop  (drop)
  );

  assign evt.evt_code    = head.code;
  assign evt.evt_ext     = head.ext;
  assign evt.evt_release = head.rel;
  assign shift           = lsh_q | rsh_q;
  assign overflow        = ovf_q;

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream produced by the PS/2 receive stage: one 8-bit scan code per one-cycle strobe. Turns Set-2 make/break/extended sequences into single key events. Buffers those events in a small show-ahead FIFO with a valid/ready handshake toward the keyboard application logic. Also tracks the Shift modifier and filters keyboard housekeeping bytes.

## Interface
Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  in  8  received scan-code byte
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head when high with evt_valid
- evt_code  out  8  head event scan code (final byte of sequence)
- evt_ext  out  1  head event had E0 prefix
- evt_release  out  1  head event is a break (F0 seen)
- shift  out  1  level: left (12) or right (59) Shift currently held
- overflow  out  1  sticky: an event was dropped because FIFO full
- clr_ovf  in  1  one-cycle pulse clears overflow

## Operation
- Byte processed only on cycles with rx_valid=1; otherwise state holds.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
- IDLE: E0→EXT; F0→BRK; E1→emit {code=E1,ext=0,rel=0}, load skip_cnt=7, →SKIP; other code→emit make, stay IDLE.
- EXT: F0→EXT_BRK; other code→emit {code,ext=1,rel=0}, →IDLE.
- BRK: code→emit {code,ext=0,rel=1}, →IDLE.
- EXT_BRK: code→emit {code,ext=1,rel=1}, →IDLE.
- SKIP: each byte decrements skip_cnt, no event; byte with skip_cnt=1 →IDLE. Housekeeping filter not applied in SKIP.
- Housekeeping bytes FA, AA, EE, FE in IDLE/EXT/BRK/EXT_BRK: ignored, state unchanged, no event.
- Error bytes 00, FF: no event, →IDLE from any state except SKIP.
- E0 or F0 arriving in EXT/BRK/EXT_BRK: E0→EXT; F0 in EXT→EXT_BRK; F0 in BRK/EXT_BRK→stay.
- Shift tracking uses non-extended events only: make 12 sets lsh, break 12 clears it; same for 59 and rsh. shift = lsh|rsh. Updates even when the event is dropped by a full FIFO.
- FIFO: push on emit; pop on evt_valid&evt_ready.
- Full and push without pop: event dropped, overflow←1.
- Full with push and pop in the same cycle: both succeed.
- Empty with pop: no effect.
- overflow: set has priority over clr_ovf in the same cycle.

## Timing
- Reset (reset=0 at an edge): FSM=IDLE, skip_cnt=0, FIFO empty. Outputs: evt_valid=0, evt_code=00, evt_ext=0, evt_release=0, shift=0, overflow=0. Partial sequences are discarded.
- Latency: final byte strobed at edge N → event visible with evt_valid=1 after edge N+1 when the FIFO was empty.
- Head outputs are stable while evt_valid=1 and evt_ready=0.
- Next entry appears the cycle after a pop.
- Throughput: one event per cycle in, one per cycle out.
- shift and overflow change one cycle after the causing strobe.
- Back-to-back rx_valid on consecutive cycles is supported.

## Structure
- Shared package ps2_pkg:
  - byte constants: SC_EXT=E0, SC_BRK=F0, SC_PAUSE=E1, SC_LSHIFT=12, SC_RSHIFT=59, ACK=FA, BAT_OK=AA, ECHO=EE, RESEND=FE, ERR0=00, ERR1=FF
  - FSM state typedef
  - 10-bit event struct {ext, rel, code}
- Sub-module ps2_event_fifo: parameterized show-ahead FIFO with pointer + count and full/empty. The decoder FSM and shift tracking stay in the top module.

## Test plan
- Stream 1C, F0 1C → events {1C,0,0} then {1C,0,1}; evt_valid first high one cycle after the 1C strobe.
- Stream E0 75, E0 F0 75 → {75,1,0}, {75,1,1}. Insert FA between E0 and 75 → same result.
- Stream 12, 1C, F0 12 → shift=1 after first strobe, 0 after the final 12; events {12,0,0},{1C,0,0},{12,0,1}. Stream E0 12 → shift unchanged.
- Pause sequence E1 14 77 E1 F0 14 F0 77 then 1C → exactly two events, {E1,0,0} and {1C,0,0}.
- evt_ready=0, push 5 makes with FIFO_DEPTH=4 → 4 stored, overflow=1, fifth dropped. Then pop with a simultaneous push → count stays 4. clr_ovf pulse → overflow=0.
- Stream E0 F0, assert reset for one cycle, then 1C → single event {1C,0,0}; all outputs at reset values during reset.
